// File: rtl/lcd_responder.sv
// lcd_responder
// -------------
// HD44780-compatible device model for the far end of a 4-bit character LCD
// bus. It decodes the nibble protocol, executes the display command subset,
// keeps an 80-byte DDRAM image and answers busy-flag reads.
//
// Optional build macro: HD44780_DATA_READ_EN
//   defined   : RS=1 reads return DDRAM[ac] (high then low nibble) and step ac.
//   undefined : RS=1 reads drive 4'h0, leave ac alone and set err.
//
// Bus strobe semantics: EN is a level strobe. The write nibble is whatever
// LCD_DATA held on the last clock where EN=1; it is consumed on the clock
// where the falling edge is seen (en_q=1, EN=0), qualified by RS/RW at that
// clock. Reads drive LCD_DATA from the clock after EN=1 is sampled until the
// clock after EN=0 is sampled.
//
// Ports
//   CLK        system clock, bus inputs synchronous to it
//   RST        asynchronous active-low reset
//   LCD_DATA   4-bit bidirectional bus data
//   RS, RW, EN register select, read/not-write, enable strobe
//   mon_addr   monitor linear index (line*40+col), 0..79
//   mon_data   DDRAM byte at mon_addr, one cycle latency
//   ac         address counter, DDRAM address form
//   busy       internal busy flag
//   disp_on    display-on bit
//   err        sticky protocol-violation flag
//   dbg_state  busy/clear sequencer state (0 idle, 1 clearing, 2 busy)
module lcd_responder #(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 100
) (
  input  logic       CLK,
  input  logic       RST,
  inout  wire  [3:0] LCD_DATA,
  input  logic       RS,
  input  logic       RW,
  input  logic       EN,
  input  logic [6:0] mon_addr,
  output logic [7:0] mon_data,
  output logic [6:0] ac,
  output logic       busy,
  output logic       disp_on,
  output logic       err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,   // clear in progress: one DDRAM entry per cycle
    ST_BUSY = 2'd2
  } state_t;

  // Counters hold (cycles - 1) so busy stays high for exactly the full count.
  localparam logic [15:0] CNT_BUSY  = 16'(BUSY_CYCLES - 1);
  localparam logic [15:0] CNT_CLEAR = 16'(CLEAR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  clr_idx_q, clr_idx_d;
  logic        en_q, en_d;
  logic [3:0]  nib_q, nib_d;
  logic        mode8_q, mode8_d;
  logic        phase_hi_q, phase_hi_d;
  logic [3:0]  hi_nib_q, hi_nib_d;
  logic [6:0]  ac_q, ac_d;
  logic        id_q, id_d;
  logic        disp_on_q, disp_on_d;
  logic        err_q, err_d;
  logic        cgram_q, cgram_d;
  logic        drive_q, drive_d;
  logic [3:0]  drv_nib_q, drv_nib_d;
  logic [7:0]  mon_data_q, mon_data_d;
  logic [7:0]  ddram_q [0:79];

  logic        mem_we;
  logic [6:0]  mem_wa;
  logic [7:0]  mem_wd;
  logic        exec;
  logic [7:0]  exec_byte;
  logic        fall;
  logic        busy_w;
  logic [3:0]  rd_nib;

  // Next address in the two-line layout (line 0: 0x00-0x27, line 1: 0x40-0x67).
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  function automatic logic [6:0] lin_idx(input logic [6:0] a);
    return a[6] ? (7'd40 + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
  endfunction

  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  assign busy_w    = (state_q != ST_IDLE);
  assign fall      = en_q & ~EN;
  assign busy      = busy_w;
  assign ac        = ac_q;
  assign disp_on   = disp_on_q;
  assign err       = err_q;
  assign mon_data  = mon_data_q;
  assign dbg_state = state_q;
  assign LCD_DATA  = drive_q ? drv_nib_q : 4'bzzzz;

  // Read nibble presented on the bus; 8-bit mode always shows the high half.
  always_comb begin
    rd_nib = 4'h0;
    if (RS) begin
`ifdef HD44780_DATA_READ_EN
      rd_nib = (mode8_q || phase_hi_q) ? ddram_q[lin_idx(ac_q)][7:4]
                                       : ddram_q[lin_idx(ac_q)][3:0];
`else
      rd_nib = 4'h0;
`endif
    end else begin
      rd_nib = (mode8_q || phase_hi_q) ? {busy_w, ac_q[6:4]} : ac_q[3:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_idx_d  = clr_idx_q;
    en_d       = EN;
    nib_d      = EN ? LCD_DATA : nib_q;
    mode8_d    = mode8_q;
    phase_hi_d = phase_hi_q;
    hi_nib_d   = hi_nib_q;
    ac_d       = ac_q;
    id_d       = id_q;
    disp_on_d  = disp_on_q;
    err_d      = err_q;
    cgram_d    = cgram_q;
    drive_d    = EN & RW;
    drv_nib_d  = rd_nib;
    mon_data_d = (mon_addr < 7'd80) ? ddram_q[mon_addr] : 8'h00;
    mem_we     = 1'b0;
    mem_wa     = lin_idx(ac_q);
    mem_wd     = 8'h20;
    exec       = 1'b0;
    exec_byte  = 8'h00;

    // Busy / clear sequencer.
    case (state_q)
      ST_FILL: begin
        mem_we    = 1'b1;
        mem_wa    = clr_idx_q;
        mem_wd    = 8'h20;
        clr_idx_d = clr_idx_q + 7'd1;
        cnt_d     = cnt_q - 16'd1;
        if (clr_idx_q == 7'd79) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (cnt_q == 16'd0) state_d = ST_IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: ;
    endcase

    // Strobe decode on the EN falling edge.
    if (fall) begin
      if (!RW) begin
        if (mode8_q) begin
          if (busy_w) begin
            err_d = 1'b1;
          end else if (nib_q == 4'h2) begin
            mode8_d    = 1'b0;
            phase_hi_d = 1'b1;
            state_d    = ST_BUSY;
            cnt_d      = CNT_BUSY;
          end else if (nib_q != 4'h3) begin
            exec      = 1'b1;
            exec_byte = {nib_q, 4'h0};
          end
        end else if (phase_hi_q) begin
          hi_nib_d   = nib_q;
          phase_hi_d = 1'b0;
        end else begin
          phase_hi_d = 1'b1;
          if (busy_w) begin
            err_d = 1'b1;
          end else begin
            exec      = 1'b1;
            exec_byte = {hi_nib_q, nib_q};
          end
        end
      end else begin
        if (!mode8_q) phase_hi_d = ~phase_hi_q;
        if (RS) begin
`ifdef HD44780_DATA_READ_EN
          if (mode8_q || !phase_hi_q) ac_d = ac_step(ac_q, id_q);
`else
          err_d = 1'b1;
`endif
        end
      end
    end

    if (exec) begin
      state_d = ST_BUSY;
      cnt_d   = CNT_BUSY;
      if (RS) begin
        // CGRAM writes are accepted on the bus but have nowhere to go.
        if (!cgram_q) begin
          mem_we = 1'b1;
          mem_wa = lin_idx(ac_q);
          mem_wd = exec_byte;
          ac_d   = ac_step(ac_q, id_q);
        end
      end else if (exec_byte == 8'h01) begin
        state_d   = ST_FILL;
        cnt_d     = CNT_CLEAR;
        clr_idx_d = 7'd0;
        ac_d      = 7'h00;
        id_d      = 1'b1;
      end else if (exec_byte[7:1] == 7'h01) begin
        ac_d  = 7'h00;
        cnt_d = CNT_CLEAR;
      end else if (exec_byte[7:2] == 6'h01) begin
        id_d = exec_byte[1];
      end else if (exec_byte[7:3] == 5'h01) begin
        disp_on_d = exec_byte[2];
      end else if (exec_byte[7:4] == 4'h1) begin
        if (!exec_byte[3]) ac_d = ac_step(ac_q, exec_byte[2]);
      end else if (exec_byte[7:5] == 3'h1) begin
        if (exec_byte[4]) begin
          mode8_d    = 1'b1;
          phase_hi_d = 1'b1;
        end
      end else if (exec_byte[7:6] == 2'h1) begin
        cgram_d = 1'b1;
      end else if (exec_byte[7]) begin
        cgram_d = 1'b0;
        if (addr_valid(exec_byte[6:0])) ac_d  = exec_byte[6:0];
        else                            err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      clr_idx_q  <= 7'd0;
      en_q       <= 1'b0;
      nib_q      <= 4'h0;
      mode8_q    <= 1'b1;
      phase_hi_q <= 1'b1;
      hi_nib_q   <= 4'h0;
      ac_q       <= 7'h00;
      id_q       <= 1'b1;
      disp_on_q  <= 1'b0;
      err_q      <= 1'b0;
      cgram_q    <= 1'b0;
      drive_q    <= 1'b0;
      drv_nib_q  <= 4'h0;
      mon_data_q <= 8'h00;
      for (int i = 0; i < 80; i++) ddram_q[i] <= 8'h20;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_idx_q  <= clr_idx_d;
      en_q       <= en_d;
      nib_q      <= nib_d;
      mode8_q    <= mode8_d;
      phase_hi_q <= phase_hi_d;
      hi_nib_q   <= hi_nib_d;
      ac_q       <= ac_d;
      id_q       <= id_d;
      disp_on_q  <= disp_on_d;
      err_q      <= err_d;
      cgram_q    <= cgram_d;
      drive_q    <= drive_d;
      drv_nib_q  <= drv_nib_d;
      mon_data_q <= mon_data_d;
      if (mem_we) ddram_q[mem_wa] <= mem_wd;
    end
  end

endmodule
